multicycle_mem_responder: RTL and testbench
===========================================

// Module: multicycle_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RISC-V core: services one fetch/load/store request at a time.
//  Backed by a byte-addressed, little-endian 32-bit-word RAM.
//  Adds programmable wait states, byte/half/word sizing and load sign/zero extension.
//  Splits misaligned accesses into two word cycles.
//  Sits between the control unit/datapath and the storage array.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
//  WAIT_STATES  0     extra idle cycles inserted before each word access (0..15)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_addr    in   32  byte address
//  req_we      in   1   1 = store, 0 = load/fetch
//  req_size    in   2   00 byte, 01 half, 10 word, 11 word (codebase default)
//  req_uns     in   1   load zero-extend (funct3[2]); ignored on stores
//  req_wdata   in   32  store data, LSB-aligned
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid: address out of range
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; wait counter=0.
//   RAM contents are not cleared.
//  Handshake: request accepted when req_valid & req_ready at a rising edge.
//   All req_* fields are latched on acceptance; later changes are ignored.
//   req_ready=1 only in IDLE.
//   resp_valid is a single-cycle pulse with no backpressure.
//  FSM: IDLE -> WAIT0 -> ACC0 -> [WAIT1 -> ACC1] -> RESP -> IDLE.
//   WAITn holds WAIT_STATES cycles; it is skipped when WAIT_STATES=0.
//   ACC1 is entered only when off+nbytes>4 (off=addr[1:0]; nbytes=1/2/4).
//   RESP drives resp_valid=1 and returns to IDLE.
//  Latency (accept edge to resp_valid high): 2+WAIT_STATES aligned; 3+2*WAIT_STATES split.
//  Range check at accept: last byte (addr+nbytes-1) >= 4*DEPTH_WORDS
//   -> go straight to RESP with resp_err=1, rdata=0, no RAM write.
//   Address wrap past 2^32 is also an error.
//  Store: byte-enable write of the relevant lanes only.
//   ACC0 writes word addr[31:2]; ACC1 writes word addr[31:2]+1 (upper lanes).
//   Bytes outside the access are unchanged.
//  Load: bytes gathered little-endian across ACC0/ACC1.
//   Byte/half are sign-extended unless req_uns=1 (zero-extended).
//   Word loads ignore req_uns.
//  resp_rdata/resp_err hold their value until the next RESP; they are valid only with resp_valid.
//  req_valid while busy: ignored (not queued); the requester must hold it.
//  Reset mid-operation: FSM to IDLE next edge, no response, and any pending ACC1 write is dropped.
//   An ACC0 write already done remains.
// STRUCTURE
//  Shared package mem_pkg:
//   mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_WORD_ALT)
//   mem_state_t
//   function size_nbytes()
//  Sub-module mem_lane_unit (combinational):
//   store: wdata+offset -> 4-bit byte enable and shifted lane data per word cycle
//   load: gathered bytes + size + uns -> extended rdata
//  Top: FSM, wait counter, request latch, RAM array with per-byte write enable.
// TESTING
//  1 WAIT_STATES=0: SW 0xDEADBEEF @0x10, LW @0x10 -> resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
//  2 SB 0x80 @0x13, LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  3 Misaligned: SW 0x11223344 @0x22, LW @0x22 -> 0x11223344, latency 3.
//   Word 0x20 lanes[3:2]=0x3344, word 0x24 lanes[1:0]=0x1122.
//  4 WAIT_STATES=3: split LH @0x27 -> resp after 9 cycles; req_ready low throughout; busy-time req_valid ignored.
//  5 DEPTH_WORDS=1024: LW @0xFFE -> resp_err=1, rdata=0; SW @0x1000 -> err=1, RAM unchanged.
//  6 Assert reset during WAIT1 of a split SW @0x3E: no resp_valid.
//   Word 0x3C upper half written, word 0x40 untouched; req_ready=1 after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: access size, FSM state codes, size decode.
// No logic of its own; no latency.
// Backpressure not applicable.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } mem_size_t;

    typedef logic [2:0] mem_state_t;

    localparam mem_state_t ST_IDLE  = 3'd0;
    localparam mem_state_t ST_WAIT0 = 3'd1;
    localparam mem_state_t ST_ACC0  = 3'd2;
    localparam mem_state_t ST_WAIT1 = 3'd3;
    localparam mem_state_t ST_ACC1  = 3'd4;
    localparam mem_state_t ST_RESP  = 3'd5;

    function automatic logic [2:0] size_nbytes(input mem_size_t sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: store data/byte enables across two words, load gather and extension.
// Purely combinational, zero latency.
// No flow control.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  mem_size_t   size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword_lo,
    input  logic [31:0] rword_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wlane_lo,
    output logic [31:0] wlane_hi,
    output logic [31:0] rdata
);

    logic [7:0]  mask;
    logic [31:0] low;

    // The two words form one 64-bit little-endian window; the offset slides the access into it.
    always_comb begin
        mask = (size == SZ_BYTE) ? 8'h01 : (size == SZ_HALF) ? 8'h03 : 8'h0f;
        {be_hi, be_lo}       = mask << off;
        {wlane_hi, wlane_lo} = {32'd0, wdata} << {off, 3'b000};
        low                  = 32'({rword_hi, rword_lo} >> {off, 3'b000});
        case (size)
            SZ_BYTE: rdata = {{24{low[7] & ~uns}}, low[7:0]};
            SZ_HALF: rdata = {{16{low[15] & ~uns}}, low[15:0]};
            default: rdata = low;
        endcase
    end

endmodule

// File: rtl/multicycle_mem_responder.sv
// One-at-a-time memory responder: wait states, sizing, misaligned split, range check.
// Latency 2+WAIT_STATES aligned, 3+2*WAIT_STATES split, 1 on range error.
// req_ready only in IDLE; resp_valid is a single pulse with no backpressure.
module multicycle_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    // DEPTH_WORDS is expected to be a power of two so the word index is a plain slice.
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT   = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    mem_state_t    state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] widx_q;
    logic [AW-1:0] widx_hi;
    logic [1:0]    off_q;
    logic          we_q;
    mem_size_t     size_q;
    logic          uns_q;
    logic          split_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_q;
    logic [31:0]   mem [DEPTH_WORDS];

    mem_size_t     req_sz;
    logic [2:0]    req_nb;
    logic [32:0]   req_last;
    logic          req_bad;
    logic          req_split;

    always_comb begin
        req_sz    = mem_size_t'(req_size);
        req_nb    = size_nbytes(req_sz);
        req_last  = {1'b0, req_addr} + {30'd0, req_nb} - 33'd1;
        req_bad   = (req_last >= LIMIT);
        req_split = ({2'b00, req_addr[1:0]} + {1'b0, req_nb}) > 4'd4;
    end

    logic [3:0]  be_lo, be_hi, wr_be;
    logic [31:0] wlane_lo, wlane_hi, wr_dat, rword_lo, ld_rdata;
    logic [AW-1:0] wr_idx;

    assign widx_hi    = widx_q + AW'(1);
    assign rword_lo   = (state == ST_ACC1) ? lo_q : mem[widx_q];
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    mem_lane_unit u_lane (
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .wdata    (wdata_q),
        .rword_lo (rword_lo),
        .rword_hi (mem[widx_hi]),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .wlane_lo (wlane_lo),
        .wlane_hi (wlane_hi),
        .rdata    (ld_rdata)
    );

    always_comb begin
        wr_be  = 4'd0;
        wr_idx = widx_q;
        wr_dat = wlane_lo;
        if (!reset && we_q && state == ST_ACC0) begin
            wr_be = be_lo;
        end else if (!reset && we_q && state == ST_ACC1) begin
            wr_be  = be_hi;
            wr_idx = widx_hi;
            wr_dat = wlane_hi;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            widx_q     <= '0;
            off_q      <= 2'd0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            split_q    <= 1'b0;
            wdata_q    <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    widx_q   <= req_addr[AW+1:2];
                    off_q    <= req_addr[1:0];
                    we_q     <= req_we;
                    size_q   <= req_sz;
                    uns_q    <= req_uns;
                    split_q  <= req_split;
                    wdata_q  <= req_wdata;
                    wait_cnt <= 4'd0;
                    if (req_bad) begin
                        state      <= ST_RESP;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        state <= NO_WAIT ? ST_ACC0 : ST_WAIT0;
                    end
                end
                ST_WAIT0, ST_WAIT1: begin
                    if (wait_cnt == WS_LAST) begin
                        wait_cnt <= 4'd0;
                        state    <= (state == ST_WAIT0) ? ST_ACC0 : ST_ACC1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ACC0: begin
                    lo_q <= mem[widx_q];
                    if (split_q) begin
                        state <= NO_WAIT ? ST_ACC1 : ST_WAIT1;
                    end else begin
                        state      <= ST_RESP;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? 32'd0 : ld_rdata;
                    end
                end
                ST_ACC1: begin
                    state      <= ST_RESP;
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? 32'd0 : ld_rdata;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: two instances (0 and 3 wait states) against a byte-array model.
module tb_multicycle_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rv [2];
    logic        rdy [2];
    logic [31:0] ra [2];
    logic        rwe [2];
    logic [1:0]  rsz [2];
    logic        runs [2];
    logic [31:0] rwd [2];
    logic        rvld [2];
    logic [31:0] rdat [2];
    logic        rerr [2];

    multicycle_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_addr(ra[0]),
        .req_we(rwe[0]), .req_size(rsz[0]), .req_uns(runs[0]), .req_wdata(rwd[0]),
        .resp_valid(rvld[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
    );

    multicycle_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_addr(ra[1]),
        .req_we(rwe[1]), .req_size(rsz[1]), .req_uns(runs[1]), .req_wdata(rwd[1]),
        .resp_valid(rvld[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          due;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [7:0]  mm [2][4096];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_lat [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Expected outcome straight from the rules: byte loop over the access, range test, latency formula.
    function automatic void model(input int i, input logic [31:0] a, input logic we,
                                  input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                  output exp_t e);
        int          nb;
        int          ws;
        logic [32:0] last;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ws   = (i == 0) ? 0 : 3;
        last = {1'b0, a} + 33'(nb - 1);
        e.err   = (last >= 33'd4096);
        e.rdata = 32'd0;
        e.due   = 0;
        if (e.err) e.lat = 1;
        else if (int'(a[1:0]) + nb > 4) e.lat = 3 + 2 * ws;
        else e.lat = 2 + ws;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < nb; b++) mm[i][int'(a) + b] = wd[8*b +: 8];
            end else begin
                v = 32'd0;
                for (int b = 0; b < nb; b++) v = v | (32'(mm[i][int'(a) + b]) << (8 * b));
                if (nb < 4 && !uns && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
                e.rdata = v;
            end
        end
    endfunction

    task automatic check_inst(input int i);
        exp_t e;
        if (qsize(i) == 0) begin
            if (rvld[i] !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp inst%0d cycle %0d: resp_valid=%b, required 0", i, cyc, rvld[i]);
            end
            return;
        end
        e = (i == 0) ? q0[0] : q1[0];
        total++;
        if (rdy[i] !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready inst%0d cycle %0d: req_ready=%b, required 0", i, cyc, rdy[i]);
        end
        if (rvld[i] === 1'b1 || cyc >= e.due) begin
            total++;
            if (rvld[i] !== 1'b1 || cyc != e.due || rdat[i] !== e.rdata || rerr[i] !== e.err) begin
                bad++;
                $display("FAIL resp inst%0d cycle %0d: valid=%b rdata=%h err=%b, required valid=1 at cycle %0d rdata=%h err=%b",
                         i, cyc, rvld[i], rdat[i], rerr[i], e.due, e.rdata, e.err);
            end
            last_lat[i]   = cyc - (e.due - e.lat);
            last_rdata[i] = rdat[i];
            last_err[i]   = rerr[i];
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) check_inst(i);
    end

    task automatic do_req(input int i, input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input bit junk);
        exp_t e;
        int   n;
        int   c0;
        model(i, a, we, sz, uns, wd, e);
        @(negedge clk);
        rv[i] = 1'b1; ra[i] = a; rwe[i] = we; rsz[i] = sz; runs[i] = uns; rwd[i] = wd;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rdy[i] !== 1'b1) begin
            chk("accept_timeout", {31'd0, rdy[i]}, 32'd1);
            rv[i] = 1'b0;
            return;
        end
        c0 = cyc;
        e.due = c0 + e.lat;
        @(posedge clk);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        if (junk) begin
            ra[i] = 32'h0; rwe[i] = 1'b1; rsz[i] = 2'd2; rwd[i] = $urandom;
            repeat (6) @(negedge clk);
        end
        rv[i] = 1'b0; ra[i] = $urandom; rwe[i] = 1'($urandom); rsz[i] = 2'($urandom);
        runs[i] = 1'($urandom); rwd[i] = $urandom;
        n = 0;
        while (qsize(i) != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          k;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rv[i] = 1'b0; ra[i] = 32'd0; rwe[i] = 1'b0;
            rsz[i] = 2'd0; runs[i] = 1'b0; rwd[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", {31'd0, rdy[i]}, 32'd1);
            chk("reset_valid", {31'd0, rvld[i]}, 32'd0);
            chk("reset_rdata", rdat[i], 32'd0);
            chk("reset_err", {31'd0, rerr[i]}, 32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 32; w++) do_req(i, 32'(4 * w), 1'b1, 2'd2, 1'b0, $urandom, 1'b0);
            do_req(i, 32'hff8, 1'b1, 2'd2, 1'b0, $urandom, 1'b0);
            do_req(i, 32'hffc, 1'b1, 2'd2, 1'b0, $urandom, 1'b0);
        end

        do_req(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hdeadbeef, 1'b0);
        do_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("lw_aligned_data", last_rdata[0], 32'hdeadbeef);
        chk("lw_aligned_lat", 32'(last_lat[0]), 32'd2);
        chk("lw_aligned_err", {31'd0, last_err[0]}, 32'd0);

        do_req(0, 32'h13, 1'b1, 2'd0, 1'b0, 32'h00000080, 1'b0);
        do_req(0, 32'h13, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
        chk("lb_sign", last_rdata[0], 32'hffffff80);
        do_req(0, 32'h13, 1'b0, 2'd0, 1'b1, 32'd0, 1'b0);
        chk("lbu_zero", last_rdata[0], 32'h00000080);
        do_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("lw_after_sb", last_rdata[0], 32'h80adbeef);

        do_req(0, 32'h22, 1'b1, 2'd2, 1'b0, 32'h11223344, 1'b0);
        chk("sw_split_lat", 32'(last_lat[0]), 32'd3);
        do_req(0, 32'h22, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("lw_split_data", last_rdata[0], 32'h11223344);
        chk("lw_split_lat", 32'(last_lat[0]), 32'd3);
        do_req(0, 32'h20, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("split_lo_word", {16'd0, last_rdata[0][31:16]}, 32'h00003344);
        do_req(0, 32'h24, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("split_hi_word", {16'd0, last_rdata[0][15:0]}, 32'h00001122);

        do_req(1, 32'h27, 1'b0, 2'd1, 1'b0, 32'd0, 1'b1);
        chk("lh_split_ws3_lat", 32'(last_lat[1]), 32'd9);
        do_req(1, 32'h0, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);

        do_req(0, 32'hffe, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("range_lw_err", {31'd0, last_err[0]}, 32'd1);
        chk("range_lw_rdata", last_rdata[0], 32'd0);
        do_req(0, 32'h1000, 1'b1, 2'd2, 1'b0, 32'h5a5a5a5a, 1'b0);
        chk("range_sw_err", {31'd0, last_err[0]}, 32'd1);
        do_req(0, 32'h0, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        do_req(0, 32'hfffffffe, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("wrap_err", {31'd0, last_err[0]}, 32'd1);

        @(negedge clk);
        rv[1] = 1'b1; ra[1] = 32'h3e; rwe[1] = 1'b1; rsz[1] = 2'd2; runs[1] = 1'b0; rwd[1] = 32'hcafef00d;
        k = 0;
        while (rdy[1] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        rv[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("ready_after_reset", {31'd0, rdy[1]}, 32'd1);
        mm[1][12'h3e] = 8'h0d;
        mm[1][12'h3f] = 8'hf0;
        repeat (12) @(negedge clk);
        do_req(1, 32'h3c, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);
        chk("reset_acc0_kept", {16'd0, last_rdata[1][31:16]}, 32'h0000f00d);
        do_req(1, 32'h40, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0);

        for (int n = 0; n < 240; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) a = 32'($urandom_range(0, 127));
            else if (r == 8) a = 32'hff8 + 32'($urandom_range(0, 7));
            else a = 32'hfffffff0 + 32'($urandom_range(0, 15));
            do_req(n % 2, a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, 1'b0);
        end

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
